rs_stream_encoder: RTL
======================

# rs_stream_encoder

Parametrised, streaming, systematic Reed-Solomon encoder. It accepts `SYM_NUM` message symbols per beat over a valid/ready handshake and computes parity with a `SYM_NUM`-symbol-parallel LFSR. It emits each codeword as the message beats passed through, followed by the parity beats, with full output backpressure. It replaces the fixed-rate encoder top in the datapath between the symbol source and the line formatter.

## Interface
- `EGF_ORDER`, 8: bits per GF(2^m) symbol.
- `PRIM_POLY`, 9'h11D: field primitive polynomial, width `EGF_ORDER+1`; alpha = 2.
- `SYM_NUM`, 4: symbols per beat, in and out.
- `RS_MSG_LEN`, 224: message symbols per codeword, K. Must be a multiple of `SYM_NUM`.
- `RS_PAR_LEN`, 16: parity symbols per codeword, 2t. Must be a multiple of `SYM_NUM`, and K+2t ≤ 2^m−1.
- Generator: g(x) = ∏_{i=0}^{2t−1} (x − alpha^i). Coefficients are computed at elaboration time.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  `SYM_NUM`×`EGF_ORDER`  message symbols. Lane `SYM_NUM−1` is the earliest (highest-degree) symbol.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_data`  out  `SYM_NUM`×`EGF_ORDER`  codeword symbols, same lane order as `in_data`.
- `out_par`  out  1  beat carries parity.
- `out_last`  out  1  final beat of the codeword.

## Operation
- States: `S_MSG` (accept message) and `S_PAR` (drain parity). Reset state is `S_MSG`.
- Counters:
  - `msg_cnt` runs 0..K/`SYM_NUM`−1.
  - `par_cnt` runs 0..2t/`SYM_NUM`−1.
  - Both reset to 0.
- Output register `oreg` = {`out_data`, `out_par`, `out_last`} with `out_valid`. It is loadable when `load_ok = !out_valid || out_ready`.
- `in_ready = (state == S_MSG) && load_ok`. This is combinational and contains no path from `in_valid`.
- Accepted message beat:
  - `oreg` ← `in_data`, with `par` = 0 and `last` = 0.
  - The LFSR absorbs `SYM_NUM` symbols, highest-degree first. Each step computes fb = sym ^ r[2t−1], then r ← (r << 1 symbol) ^ fb·g[0..2t−1].
  - `msg_cnt` increments.
  - On the last message beat, `msg_cnt` wraps to 0 and the state moves to `S_PAR`.
- In `S_PAR`, each cycle with `load_ok`:
  - `oreg` ← the top `SYM_NUM` LFSR symbols. r[2t−1] goes in lane `SYM_NUM−1`.
  - `par` = 1, and `last` = 1 when `par_cnt` is at its final value.
  - The LFSR shifts up by `SYM_NUM` symbols, zero-filled.
  - `par_cnt` increments.
  - On the final parity beat, `par_cnt` wraps to 0, the LFSR is zeroed, and the state returns to `S_MSG`.
- When `load_ok` is true but there is no new load (no accepted input in `S_MSG`), `out_valid` clears. Otherwise `oreg` holds stable while `out_valid && !out_ready`.
- GF arithmetic: add is XOR. Constant multiplies are XOR networks derived from `PRIM_POLY`; there are no lookup RAMs.
- No codeword delimiter is accepted on the input. Framing is counter-based only.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_par` = 0, `out_last` = 0.
  - Internal: LFSR = 0, `S_MSG`, counters = 0.
  - `in_ready` = 1 on the first cycle after reset deasserts.
- Latency: an accepted beat appears on `out_data` one cycle later.
- The first parity beat is valid the cycle after the last message beat's output is consumed. It is sooner if `out_ready` was high: back-to-back, with no bubble on the output.
- Throughput:
  - The output runs at 1 beat/cycle with `out_ready` held high.
  - The input stalls 2t/`SYM_NUM` cycles per codeword.
- Simultaneous events:
  - Consume and load in the same cycle proceed back-to-back.
  - The last parity load and the next message acceptance cannot coincide. `in_ready` becomes 1 only after the state is back in `S_MSG`.
- Reset asserted mid-codeword discards the partial codeword immediately. No partial output follows.
- `out_data` must not change while `out_valid && !out_ready`.

## Test plan
- Small configuration: `SYM_NUM`=2, K=4, 2t=2, default field, so g = x²+3x+2.
  - Message 00 00 00 01 → out beats [00,00], [00,01], then parity [03,02] with `out_par`=1, `out_last`=1.
- Same configuration, message 00 00 01 00 → parity [07,06].
- All-zero message with default parameters → 56 zero message beats, then 4 zero parity beats, `out_last` only on beat 60.
- Random `out_ready` (50%) over 100 random codewords → output stream matches the software RS model bit-exactly; `out_data` is stable under stall; there are no dropped or duplicated beats.
- Assert `rst` after beat 3 of a codeword, then send a fresh message → `out_valid` = 0 during reset, and the new codeword's parity matches the model (no residue from the aborted codeword).
- Continuous `in_valid` and `out_ready` → `in_ready` is low for exactly 2t/`SYM_NUM` cycles per codeword, and the output has no bubbles.

Source files
------------

// File: rtl/rs_stream_encoder_if.sv
// Streaming handshake bundle for the RS encoder: message beats in, codeword beats out.
// master drives the message side and the output backpressure, slave is the encoder.
interface rs_stream_encoder_if #(
    parameter int EGF_ORDER = 8,
    parameter int SYM_NUM   = 4
);
    logic                               in_valid;
    logic                               in_ready;
    logic [SYM_NUM-1:0][EGF_ORDER-1:0]  in_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [SYM_NUM-1:0][EGF_ORDER-1:0]  out_data;
    logic                               out_par;
    logic                               out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_par, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_par, out_last
    );
endinterface

// File: rtl/rs_stream_encoder.sv
// Systematic streaming Reed-Solomon encoder: SYM_NUM-symbol-parallel LFSR, message beats
// pass through, then RS_PAR_LEN/SYM_NUM parity beats. RS_MSG_LEN and RS_PAR_LEN must be multiples of SYM_NUM.
module rs_stream_encoder #(
    parameter int                 EGF_ORDER  = 8,
    parameter logic [EGF_ORDER:0] PRIM_POLY  = 9'h11D,
    parameter int                 SYM_NUM    = 4,
    parameter int                 RS_MSG_LEN = 224,
    parameter int                 RS_PAR_LEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rs_stream_encoder_if.slave    bus
);
    localparam int M         = EGF_ORDER;
    localparam int NPAR      = RS_PAR_LEN;
    localparam int MSG_BEATS = RS_MSG_LEN / SYM_NUM;
    localparam int PAR_BEATS = RS_PAR_LEN / SYM_NUM;
    localparam int MW        = (MSG_BEATS > 1) ? $clog2(MSG_BEATS) : 1;
    localparam int PW        = (PAR_BEATS > 1) ? $clog2(PAR_BEATS) : 1;

    typedef logic [M-1:0] sym_t;
    typedef enum logic {S_MSG, S_PAR} state_t;

    // Multiply by a constant b collapses to a pure XOR network after elaboration.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ x;
            x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [NPAR:0][M-1:0] gen_poly();
        logic [NPAR:0][M-1:0] g;
        sym_t                 a;
        g    = '0;
        g[0] = sym_t'(1);
        a    = sym_t'(1);
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], a);
            g[0] = gf_mul(g[0], a);
            a    = gf_mul(a, sym_t'(2));
        end
        return g;
    endfunction

    localparam logic [NPAR:0][M-1:0] GEN = gen_poly();

    state_t                      r_state, w_state_next;
    logic [MW-1:0]               r_msg_cnt;
    logic [PW-1:0]               r_par_cnt;
    logic [NPAR-1:0][M-1:0]      r_lfsr;
    logic [SYM_NUM-1:0][M-1:0]   r_out_data;
    logic                        r_out_valid, r_out_par, r_out_last;

    logic                        w_load_ok, w_in_ready, w_in_fire, w_par_fire;
    logic                        w_msg_last, w_par_last;
    logic [NPAR-1:0][M-1:0]      w_lfsr_abs, w_lfsr_shift;
    logic [SYM_NUM-1:0][M-1:0]   w_par_out;

    assign w_load_ok    = !r_out_valid || bus.out_ready;
    assign w_msg_last   = (r_msg_cnt == MW'(MSG_BEATS - 1));
    assign w_par_last   = (r_par_cnt == PW'(PAR_BEATS - 1));
    assign w_lfsr_shift = r_lfsr << (SYM_NUM * M);
    assign w_par_out    = r_lfsr[NPAR-1 -: SYM_NUM];

    // Absorb one beat, earliest (highest-degree) lane first.
    always_comb begin
        sym_t fb;
        fb         = '0;
        w_lfsr_abs = r_lfsr;
        for (int s = SYM_NUM - 1; s >= 0; s--) begin
            fb         = bus.in_data[s] ^ w_lfsr_abs[NPAR-1];
            w_lfsr_abs = w_lfsr_abs << M;
            for (int j = 0; j < NPAR; j++) w_lfsr_abs[j] = w_lfsr_abs[j] ^ gf_mul(fb, GEN[j]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_MSG;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_MSG:   if (w_in_fire && w_msg_last)  w_state_next = S_PAR;
            S_PAR:   if (w_par_fire && w_par_last) w_state_next = S_MSG;
            default: w_state_next = S_MSG;
        endcase
    end

    // in_ready depends only on state and output occupancy, never on in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        w_in_fire  = 1'b0;
        w_par_fire = 1'b0;
        case (r_state)
            S_MSG: begin
                w_in_ready = w_load_ok;
                w_in_fire  = w_load_ok && bus.in_valid;
            end
            S_PAR:   w_par_fire = w_load_ok;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_msg_cnt   <= '0;
            r_par_cnt   <= '0;
            r_lfsr      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_par   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_in_fire) begin
            r_out_data  <= bus.in_data;
            r_out_valid <= 1'b1;
            r_out_par   <= 1'b0;
            r_out_last  <= 1'b0;
            r_lfsr      <= w_lfsr_abs;
            r_msg_cnt   <= w_msg_last ? '0 : r_msg_cnt + 1'b1;
        end else if (w_par_fire) begin
            r_out_data  <= w_par_out;
            r_out_valid <= 1'b1;
            r_out_par   <= 1'b1;
            r_out_last  <= w_par_last;
            r_lfsr      <= w_par_last ? '0 : w_lfsr_shift;
            r_par_cnt   <= w_par_last ? '0 : r_par_cnt + 1'b1;
        end else if (w_load_ok) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_par   = r_out_par;
    assign bus.out_last  = r_out_last;
endmodule
